twiddle_cmul: RTL and testbench

- Consumer side of the twiddle-factor stream. Accepts sign-magnitude cos/sin twiddles on a valid/ready handshake.
- Joins each twiddle with one complex data sample and multiplies: y = x * (c + j*s), where c and s are the signed values after applying each sign bit.
- Sits between the twiddle generator and the FFT butterfly stage.
- Output is a pipelined, rounded, width-restored complex product on its own valid/ready interface.

---
 rtl/twiddle_cmul.sv | 135 +++++++++++++
 tb/tb_twiddle_cmul.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_cmul.sv
// twiddle_cmul: joins a sign-magnitude twiddle stream with a complex data
// stream and emits y = x * (c + j*s) through a 3-stage elastic pipeline.
// Result is rounded half up, shifted back to data scale and reduced to DW.
// Optional macro TWIDDLE_CMUL_SAT_EN: saturate on reduction to DW bits
// (default build wraps to the low DW bits). Latency is the same either way.
module twiddle_cmul #(
  parameter int DW         = 16,
  parameter int LAST_STAGE = 8,
  parameter int PARL       = 1,
  localparam int TW_W      = (LAST_STAGE < 5 ? 10 : LAST_STAGE + 5) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tw_tvalid,
  output logic                           tw_tready,
  input  logic [PARL-1:0][TW_W-1:0]      tw_cos,
  input  logic [PARL-1:0]                tw_cos_sign,
  input  logic [PARL-1:0][TW_W-1:0]      tw_sin,
  input  logic [PARL-1:0]                tw_sin_sign,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic signed [PARL-1:0][DW-1:0] s_re,
  input  logic signed [PARL-1:0][DW-1:0] s_im,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic signed [PARL-1:0][DW-1:0] m_re,
  output logic signed [PARL-1:0][DW-1:0] m_im
);
  localparam int CW = TW_W + 1;       // signed twiddle width
  localparam int PW = DW + TW_W + 1;  // single product width
  localparam int SW = PW + 1;         // sum/difference of two products
  localparam int SH = TW_W - 1;       // 1.0 = 2^SH
  localparam logic signed [SW-1:0] RND = SW'(2 ** (TW_W - 2));

  // Round half up, rescale, then bring back to DW bits.
  function automatic logic signed [DW-1:0] reduce(input logic signed [SW-1:0] sum);
`ifdef TWIDDLE_CMUL_SAT_EN
    logic signed [SW-1:0] q;
    logic signed [SW-1:0] q_max;
    logic signed [SW-1:0] q_min;
    q_max = SW'(2 ** (DW - 1) - 1);
    q_min = SW'(-(2 ** (DW - 1)));
    q = (sum + RND) >>> SH;
    if (q > q_max)
      reduce = DW'(q_max);
    else if (q < q_min)
      reduce = DW'(q_min);
    else
      reduce = DW'(q);
`else
    reduce = DW'((sum + RND) >>> SH);
`endif
  endfunction

  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;
  logic accept, ld2, ld3;

  // A stage can take new contents when empty or when it empties this cycle.
  assign rdy3 = !v3 || m_tready;
  assign rdy2 = !v2 || rdy3;
  assign rdy1 = !v1 || rdy2;
  assign ld2  = v1 && rdy2;
  assign ld3  = v2 && rdy3;

  // Each ready looks only at the other stream's valid, never its own.
  assign accept    = tw_tvalid && s_tvalid && rdy1;
  assign tw_tready = s_tvalid && rdy1;
  assign s_tready  = tw_tvalid && rdy1;
  assign m_tvalid  = v3;

  // Stage valid bits; bubbles collapse because every stage loads when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (rdy1) v1 <= accept;
      if (rdy2) v2 <= v1;
      if (rdy3) v3 <= v2;
    end
  end

  genvar g;
  generate
    for (g = 0; g < PARL; g++) begin : g_lane
      logic signed [CW-1:0] c_in, s_in;
      logic signed [CW-1:0] c1, s1;
      logic signed [DW-1:0] xr1, xi1;
      logic signed [PW-1:0] p_rc, p_is, p_rs, p_ic;
      logic signed [DW-1:0] re3, im3;

      assign c_in = tw_cos_sign[g] ? -$signed({1'b0, tw_cos[g]}) : $signed({1'b0, tw_cos[g]});
      assign s_in = tw_sin_sign[g] ? -$signed({1'b0, tw_sin[g]}) : $signed({1'b0, tw_sin[g]});

      // Lane datapath: operands, four partial products, combine and reduce.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          c1   <= '0;
          s1   <= '0;
          xr1  <= '0;
          xi1  <= '0;
          p_rc <= '0;
          p_is <= '0;
          p_rs <= '0;
          p_ic <= '0;
          re3  <= '0;
          im3  <= '0;
        end else begin
          if (accept) begin
            c1  <= c_in;
            s1  <= s_in;
            xr1 <= $signed(s_re[g]);
            xi1 <= $signed(s_im[g]);
          end
          if (ld2) begin
            p_rc <= PW'(xr1) * PW'(c1);
            p_is <= PW'(xi1) * PW'(s1);
            p_rs <= PW'(xr1) * PW'(s1);
            p_ic <= PW'(xi1) * PW'(c1);
          end
          if (ld3) begin
            re3 <= reduce(SW'(p_rc) - SW'(p_is));
            im3 <= reduce(SW'(p_rs) + SW'(p_ic));
          end
        end
      end

      assign m_re[g] = re3;
      assign m_im[g] = im3;
    end
  endgenerate

endmodule

// File: tb/tb_twiddle_cmul.sv
// Bench for twiddle_cmul: directed vector table, join/backpressure/reset
// sequences, and a randomized phase checked by a scoreboard model.
module tb_twiddle_cmul;
  localparam int DW   = 16;
  localparam int PARL = 1;
  localparam int TW_W = 14;
  localparam int ONE  = 8192;

`ifdef TWIDDLE_CMUL_SAT_EN
  localparam int OVF_RE  = 32767;
  localparam int NEG1_RE = 32767;
`else
  localparam int OVF_RE  = -2;
  localparam int NEG1_RE = -32768;
`endif

  logic clk;
  logic rst_n;
  logic tw_tvalid, tw_tready;
  logic [PARL-1:0][TW_W-1:0] tw_cos, tw_sin;
  logic [PARL-1:0] tw_cos_sign, tw_sin_sign;
  logic s_tvalid, s_tready;
  logic signed [PARL-1:0][DW-1:0] s_re, s_im;
  logic m_tvalid, m_tready;
  logic signed [PARL-1:0][DW-1:0] m_re, m_im;

  twiddle_cmul #(.DW(DW), .LAST_STAGE(8), .PARL(PARL)) dut (
    .clk(clk), .rst_n(rst_n),
    .tw_tvalid(tw_tvalid), .tw_tready(tw_tready),
    .tw_cos(tw_cos), .tw_cos_sign(tw_cos_sign),
    .tw_sin(tw_sin), .tw_sin_sign(tw_sin_sign),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_re(s_re), .s_im(s_im),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_re(m_re), .m_im(m_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: signed twiddle, exact complex product, floor((v + 1/2) / 1.0), reduce.
  function automatic int reduce_ref(input longint v);
    longint q;
    q = (v + ONE / 2) >>> 13;  // arithmetic shift on longint is floor division by 8192
`ifdef TWIDDLE_CMUL_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
`else
    q = q & 64'hFFFF;
    if (q >= 32768) q = q - 65536;
    return int'(q);
`endif
  endfunction

  function automatic void model(input int cm, input int cs, input int sm, input int ss,
                                input int xr, input int xi, output int er, output int ei);
    longint c, s;
    c = (cs != 0) ? -longint'(cm) : longint'(cm);
    s = (ss != 0) ? -longint'(sm) : longint'(sm);
    er = reduce_ref(longint'(xr) * c - longint'(xi) * s);
    ei = reduce_ref(longint'(xr) * s + longint'(xi) * c);
  endfunction

  typedef struct { int re; int im; } exp_t;
  exp_t expq[$];
  int acc_cnt = 0;
  int out_cnt = 0;
  bit stall = 0;
  int hold_re, hold_im;
  logic rand_rdy = 0;

  // Scoreboard: values are stable half a cycle from the edge they describe.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", longint'(m_tvalid), 1);
        chk("hold_re", longint'($signed(m_re[0])), hold_re);
        chk("hold_im", longint'($signed(m_im[0])), hold_im);
      end
      if (m_tvalid && m_tready) begin
        out_cnt++;
        chk("out_expected", longint'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          exp_t e;
          e = expq.pop_front();
          chk("sb_re", longint'($signed(m_re[0])), e.re);
          chk("sb_im", longint'($signed(m_im[0])), e.im);
        end
      end
      if (tw_tvalid && tw_tready && s_tvalid && s_tready) begin
        exp_t e;
        model(int'(tw_cos[0]), int'(tw_cos_sign[0]), int'(tw_sin[0]), int'(tw_sin_sign[0]),
              int'($signed(s_re[0])), int'($signed(s_im[0])), e.re, e.im);
        expq.push_back(e);
        acc_cnt++;
      end
      stall = m_tvalid && !m_tready;
      hold_re = int'($signed(m_re[0]));
      hold_im = int'($signed(m_im[0]));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  end

  task automatic rand_data();
    tw_cos[0]      = TW_W'($urandom_range(0, ONE));
    tw_cos_sign[0] = 1'($urandom_range(0, 1));
    tw_sin[0]      = TW_W'($urandom_range(0, ONE));
    tw_sin_sign[0] = 1'($urandom_range(0, 1));
    s_re[0]        = DW'($urandom);
    s_im[0]        = DW'($urandom);
  endtask

  typedef struct {
    int cm; int cs; int sm; int ss; int xr; int xi; int er; int ei;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    tw_cos[0] = TW_W'(v.cm); tw_cos_sign[0] = 1'(v.cs);
    tw_sin[0] = TW_W'(v.sm); tw_sin_sign[0] = 1'(v.ss);
    s_re[0] = DW'(v.xr); s_im[0] = DW'(v.xi);
    tw_tvalid = 1; s_tvalid = 1;
    @(negedge clk);
    chk($sformatf("vec%0d_ready", idx), longint'(tw_tready && s_tready), 1);
    @(posedge clk); #1;
    tw_tvalid = 0; s_tvalid = 0;
    lat = 1;
    while (!m_tvalid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 3);
    chk($sformatf("vec%0d_re", idx), longint'($signed(m_re[0])), v.er);
    chk($sformatf("vec%0d_im", idx), longint'($signed(m_im[0])), v.ei);
  endtask

  task automatic send_rand();
    int n;
    bit done;
    n = 0;
    done = 0;
    rand_data();
    while (!done && n < 200) begin
      tw_tvalid = ($urandom_range(0, 3) != 0);
      s_tvalid  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      done = tw_tvalid && s_tvalid && tw_tready && s_tready;
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("send_timeout", n, 0);
    tw_tvalid = 0; s_tvalid = 0;
  endtask

  vec_t vecs[6];

  initial begin
    int base, obase, last, n;
    rst_n = 0; m_tready = 1; tw_tvalid = 0; s_tvalid = 0;
    tw_cos = '0; tw_sin = '0; tw_cos_sign = '0; tw_sin_sign = '0;
    s_re = '0; s_im = '0;

    vecs[0] = '{cm: ONE, cs: 0, sm: 0,   ss: 0, xr: 1000,   xi: -2000,  er: 1000,    ei: -2000};
    vecs[1] = '{cm: 0,   cs: 0, sm: ONE, ss: 1, xr: 1000,   xi: -2000,  er: -2000,   ei: -1000};
    vecs[2] = '{cm: 4096, cs: 0, sm: 0,  ss: 0, xr: 3,      xi: -3,     er: 2,       ei: -1};
    vecs[3] = '{cm: ONE, cs: 0, sm: ONE, ss: 0, xr: 32767,  xi: -32767, er: OVF_RE,  ei: 0};
    vecs[4] = '{cm: 5793, cs: 0, sm: 5793, ss: 1, xr: 10000, xi: 0,     er: 7072,    ei: -7072};
    vecs[5] = '{cm: ONE, cs: 1, sm: 0,   ss: 0, xr: -32768, xi: 0,      er: NEG1_RE, ei: 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(m_tvalid), 0);
    chk("rst_re", longint'($signed(m_re[0])), 0);
    chk("rst_im", longint'($signed(m_im[0])), 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Directed vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    repeat (3) @(posedge clk);
    #1;

    // Join: twiddle alone is never consumed
    base = acc_cnt;
    tw_tvalid = 1; s_tvalid = 0;
    rand_data();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("join_tw_tready", longint'(tw_tready), 0);
      chk("join_s_tready", longint'(s_tready), 1);
      chk("join_m_tvalid", longint'(m_tvalid), 0);
      @(posedge clk); #1;
    end
    tw_tvalid = 0;
    chk("join_consumed", acc_cnt - base, 0);

    // Backpressure: fill to 3, stall 10 clocks, then stream 20 in total
    base = acc_cnt; obase = out_cnt;
    m_tready = 0;
    rand_data();
    tw_tvalid = 1; s_tvalid = 1;
    last = acc_cnt;
    repeat (10) begin
      @(posedge clk); #1;
      if (acc_cnt != last) begin last = acc_cnt; rand_data(); end
    end
    chk("bp_accepted", acc_cnt - base, 3);
    @(negedge clk);
    chk("bp_tw_tready", longint'(tw_tready), 0);
    chk("bp_s_tready", longint'(s_tready), 0);
    @(posedge clk); #1;
    m_tready = 1;
    n = 0;
    while (acc_cnt - base < 20 && n < 100) begin
      @(posedge clk); #1;
      if (acc_cnt != last) begin last = acc_cnt; rand_data(); end
      n++;
    end
    tw_tvalid = 0; s_tvalid = 0;
    chk("bp_total_accepted", acc_cnt - base, 20);
    n = 0;
    while (out_cnt - obase < 20 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bp_total_out", out_cnt - obase, 20);
    chk("bp_queue_empty", expq.size(), 0);

    // Randomized traffic with random downstream ready
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) send_rand();
    rand_rdy = 0;
    @(posedge clk); #1;
    m_tready = 1;
    n = 0;
    while ((expq.size() != 0 || m_tvalid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rand_drain", expq.size(), 0);

    // Reset with two pairs in flight
    base = acc_cnt; obase = out_cnt;
    m_tready = 0;
    rand_data();
    tw_tvalid = 1; s_tvalid = 1;
    @(posedge clk); #1;
    rand_data();
    @(posedge clk); #1;
    tw_tvalid = 0; s_tvalid = 0;
    @(posedge clk); #1;
    chk("rst_inflight_accepted", acc_cnt - base, 2);
    chk("rst_pre_valid", longint'(m_tvalid), 1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_valid", longint'(m_tvalid), 0);
    chk("rst_async_re", longint'($signed(m_re[0])), 0);
    @(posedge clk); #1;
    rst_n = 1;
    m_tready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_ghost_out", out_cnt - obase, 0);
    chk("rst_post_valid", longint'(m_tvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
